// File: rtl/traffic_pkg.sv
// Shared interval-select encoding for the traffic-light timer and its FSM.
package traffic_pkg;

  typedef logic [1:0] ic_sel_t;

  localparam ic_sel_t IC_YELLOW = 2'b00;
  localparam ic_sel_t IC_RED    = 2'b01;
  localparam ic_sel_t IC_NGREEN = 2'b10;
  localparam ic_sel_t IC_EGREEN = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a debounce counter. The output changes only
// after DB_CYCLES consecutive synchronised samples disagree with it.
module sensor_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out
);

  localparam int unsigned DBW = $clog2(DB_CYCLES + 1);

  logic           sync_q1;
  logic           car_s;
  logic           level_q;
  logic [DBW-1:0] db_cnt_q;

  // Bring the asynchronous sensor into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      car_s   <= 1'b0;
    end else begin
      sync_q1 <= raw_in;
      car_s   <= sync_q1;
    end
  end

  // Count consecutive disagreeing samples; adopt the new level on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else if (car_s == level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
      level_q  <= car_s;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/traffic_interval_timer.sv
// Interval countdown and status-flag decode for the traffic-light FSM, plus the
// conditioned east-road car sensor.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int unsigned T_SHORT   = 3,
  parameter int unsigned T_RED     = 2,
  parameter int unsigned T_LONG    = 10,
  parameter int unsigned CW        = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  ic_sel_t s_ic,
  input  logic    en_ic,
  input  logic    car_e_raw,
  output logic    not_r,
  output logic    c_and_l,
  output logic    en_s,
  output logic    l_or_notc,
  output logic    car_e
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] load_val;
  ic_sel_t       cur_sel_q;
  logic          armed_q;
  logic          load;
  logic          sel_match;
  logic          expired;
  logic          done;

  sensor_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_sensor_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (car_e_raw),
    .level_out (car_e)
  );

  // Interval length for the requested select.
  always_comb begin
    load_val = CW'(T_LONG);
    unique case (s_ic)
      IC_YELLOW: load_val = CW'(T_SHORT);
      IC_RED:    load_val = CW'(T_RED);
      IC_NGREEN: load_val = CW'(T_LONG);
      IC_EGREEN: load_val = CW'(T_LONG);
      default:   load_val = CW'(T_LONG);
    endcase
  end

  // First enabled cycle after reset, or a new select, reloads the interval.
  assign load = en_ic && (!armed_q || (s_ic != cur_sel_q));

  // Countdown state: reload, saturating decrement, or hold while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      cur_sel_q <= IC_YELLOW;
      armed_q   <= 1'b0;
    end else if (load) begin
      count_q   <= load_val;
      cur_sel_q <= s_ic;
      armed_q   <= 1'b1;
    end else if (en_ic && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // The select-match term hides stale flags in the cycle before a reload.
  assign sel_match = en_ic && armed_q && (s_ic == cur_sel_q);
  assign expired   = (count_q == '0);
  assign done      = sel_match && expired;

  assign en_s      = done && (cur_sel_q == IC_YELLOW);
  assign not_r     = done && (cur_sel_q == IC_RED);
  assign c_and_l   = done && (cur_sel_q == IC_NGREEN) && car_e;
  assign l_or_notc = sel_match && (cur_sel_q == IC_EGREEN) && (expired || !car_e);

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboard bench: a driver applies stimulus one cycle at a time and queues the
// outputs a behavioural model predicts; a monitor pops and compares each cycle.
module tb_traffic_interval_timer;

  localparam int T_SHORT   = 3;
  localparam int T_RED     = 2;
  localparam int T_LONG    = 10;
  localparam int DB_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] s_ic = 2'b00;
  logic       en_ic = 1'b0;
  logic       car_e_raw = 1'b0;
  logic       not_r, c_and_l, en_s, l_or_notc, car_e;

  always #5 clk = ~clk;

  traffic_interval_timer #(
    .T_SHORT   (T_SHORT),
    .T_RED     (T_RED),
    .T_LONG    (T_LONG),
    .CW        (16),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_ic      (s_ic),
    .en_ic     (en_ic),
    .car_e_raw (car_e_raw),
    .not_r     (not_r),
    .c_and_l   (c_and_l),
    .en_s      (en_s),
    .l_or_notc (l_or_notc),
    .car_e     (car_e)
  );

  typedef struct {
    logic not_r;
    logic c_and_l;
    logic en_s;
    logic l_or_notc;
    logic car_e;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: interval tracked as enabled edges elapsed since its start;
  // sensor tracked as a history of raw samples and of synchronised samples.
  bit m_armed;
  int m_sel;
  int m_elapsed;
  bit m_car;
  bit raw_hist[$];
  bit db_hist[$];

  function automatic int t_of(input int sel);
    if (sel == 0) return T_SHORT;
    if (sel == 1) return T_RED;
    return T_LONG;
  endfunction

  task automatic model_clear();
    m_armed   = 1'b0;
    m_sel     = 0;
    m_elapsed = 0;
    m_car     = 1'b0;
    raw_hist  = {};
    db_hist   = {};
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit seen;
    bit all_diff;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (en_ic) begin
      if (!m_armed || int'(s_ic) != m_sel) begin
        m_armed   = 1'b1;
        m_sel     = int'(s_ic);
        m_elapsed = 0;
      end else if (m_elapsed < t_of(m_sel)) begin
        m_elapsed++;
      end
    end
    // The sample reaching the debouncer is the raw value from two edges earlier.
    seen = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 1'b0;
    raw_hist.push_back(car_e_raw);
    if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    db_hist.push_back(seen);
    if (db_hist.size() > DB_CYCLES) void'(db_hist.pop_front());
    if (db_hist.size() == DB_CYCLES) begin
      all_diff = 1'b1;
      foreach (db_hist[i]) if (db_hist[i] == m_car) all_diff = 1'b0;
      if (all_diff) m_car = ~m_car;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit   match, expd;
    match       = en_ic && m_armed && (int'(s_ic) == m_sel);
    expd        = m_elapsed >= t_of(m_sel);
    e.en_s      = match && expd && (m_sel == 0);
    e.not_r     = match && expd && (m_sel == 1);
    e.c_and_l   = match && expd && (m_sel == 2) && m_car;
    e.l_or_notc = match && (m_sel == 3) && (expd || !m_car);
    e.car_e     = m_car;
    return e;
  endfunction

  // One cycle: model takes the edge, new inputs go on just after it.
  task automatic step(input bit r, input bit e, input logic [1:0] s, input bit raw);
    @(posedge clk);
    model_edge();
    #1;
    rst_n     = r;
    en_ic     = e;
    s_ic      = s;
    car_e_raw = raw;
    if (!r) model_clear();
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: compare the DUT against each queued prediction mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("not_r", not_r, e.not_r);
        chk("c_and_l", c_and_l, e.c_and_l);
        chk("en_s", en_s, e.en_s);
        chk("l_or_notc", l_or_notc, e.l_or_notc);
        chk("car_e", car_e, e.car_e);
        checks++;
        if ($countones({not_r, c_and_l, en_s, l_or_notc}) > 1) begin
          errors++;
          $display("FAIL onehot at %0t: got %b expected at most one flag", $time,
                   {not_r, c_and_l, en_s, l_or_notc});
        end
      end
    end
  end

  initial begin
    logic [1:0] rs;
    bit         rraw;
    model_clear();
    // Reset, then all-red with the car sensor going high.
    repeat (3) step(0, 0, 2'b00, 0);
    repeat (8) step(1, 1, 2'b01, 1);
    // North green with a car waiting, then the car leaves.
    repeat (14) step(1, 1, 2'b10, 1);
    repeat (8) step(1, 1, 2'b10, 0);
    // North green again without a car.
    repeat (3) step(1, 1, 2'b01, 0);
    repeat (14) step(1, 1, 2'b10, 0);
    // East green: car present, then falling 4 cycles after the load.
    repeat (8) step(1, 1, 2'b01, 1);
    repeat (4) step(1, 1, 2'b11, 1);
    repeat (12) step(1, 1, 2'b11, 0);
    // Short glitch rejected, long pulse accepted.
    repeat (2) step(1, 1, 2'b01, 1);
    repeat (6) step(1, 1, 2'b01, 0);
    repeat (8) step(1, 1, 2'b01, 1);
    // Yellow with an enable pause.
    step(1, 1, 2'b00, 1);
    repeat (5) step(1, 0, 2'b00, 1);
    repeat (4) step(1, 1, 2'b00, 1);
    // Reset mid north-green, release with the same select.
    repeat (6) step(1, 1, 2'b10, 1);
    repeat (2) step(0, 1, 2'b10, 1);
    repeat (16) step(1, 1, 2'b10, 1);
    // Randomised traffic.
    rs   = 2'b00;
    rraw = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        repeat (2) step(0, 1, rs, rraw);
      end else begin
        if ($urandom_range(0, 14) == 0) rs = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 11) == 0) rraw = ~rraw;
        step(1, $urandom_range(0, 9) != 0, rs, rraw);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
